// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM state encoding, memory geometry and the default HALT word.
package imem_loader_pkg;

  localparam int unsigned IMEM_BYTES = 256;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word.
// Ports:
//   clk, reset    clock, async active-high reset
//   clear         zero the byte counter (start of a new load)
//   accept        consume rx_data this cycle
//   rx_data       incoming byte
//   word_ready_c  combinational: lane 3 accepted this cycle, word_c complete
//   word_c        combinational: packed word including the current byte in [31:24]
module imem_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  rx_data,
  output logic        word_ready_c,
  output logic [31:0] word_c
);

  logic [1:0]  byte_cnt;
  logic [23:0] pack;

  // Lanes 0..2 are stored; lane 3 is taken straight from rx_data so the
  // word is available on the same cycle the last byte arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt <= 2'd0;
      pack     <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (accept) begin
      case (byte_cnt)
        2'd0:    pack[7:0]   <= rx_data;
        2'd1:    pack[15:8]  <= rx_data;
        2'd2:    pack[23:16] <= rx_data;
        default: ;
      endcase
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign word_ready_c = accept && (byte_cnt == 2'd3);
  assign word_c       = {rx_data, pack};

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into words and writes them to the
// instruction memory at byte addresses 0,4,8,... until HALT or memory full,
// holding loading high to stall the pipeline meanwhile.
// Ports:
//   clk, reset  clock, async active-high reset
//   start       one-cycle pulse, begins a load from IDLE or DONE
//   rx_data     received byte; rx_valid marks it valid (no backpressure)
//   write_en    one-cycle memory write strobe
//   addr_wr     byte address of the written word
//   data        word to write (stream byte 0 in [7:0])
//   loading     high while in LOAD
//   done        high while in DONE
//   overflow    load ended by full memory without HALT
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              write_en,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [31:0]       data,
  output logic              loading,
  output logic              done,
  output logic              overflow
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] word_addr;
  logic              load_start_c;
  logic              write_c;
  logic              overflow_c;
  logic              accept_c;
  logic              word_ready_c;
  logic [31:0]       word_c;
  logic              last_addr_c;

  assign accept_c    = (state_q == LOAD) && rx_valid;
  assign last_addr_c = (word_addr[ADDR_W-1:2] == '1);

  imem_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (load_start_c),
    .accept       (accept_c),
    .rx_data      (rx_data),
    .word_ready_c (word_ready_c),
    .word_c       (word_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and control decode
  always_comb begin
    state_d      = state_q;
    load_start_c = 1'b0;
    write_c      = 1'b0;
    overflow_c   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = LOAD;
          load_start_c = 1'b1;
        end
      end
      LOAD: begin
        if (word_ready_c) begin
          write_c = 1'b1;
          if (word_c == HALT_WORD) begin
            state_d = DONE;
          end else if (last_addr_c) begin
            state_d    = DONE;
            overflow_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and word address; loading/done follow the next
  // state so the final strobe already sees done=1 and loading=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_addr <= '0;
      write_en  <= 1'b0;
      addr_wr   <= '0;
      data      <= 32'd0;
      loading   <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      write_en <= write_c;
      loading  <= (state_d == LOAD);
      done     <= (state_d == DONE);
      if (load_start_c) begin
        word_addr <= '0;
        overflow  <= 1'b0;
      end
      if (write_c) begin
        addr_wr <= word_addr;
        data    <= word_c;
        if (state_d == LOAD) word_addr <= word_addr + ADDR_W'(WORD_BYTES);
      end
      if (overflow_c) overflow <= 1'b1;
    end
  end

endmodule
